// File: rtl/weight_mem_loader_if.sv
// Config-stream and weight-memory write bus bundle for weight_mem_loader.
// slave = loader side, master = stream source / memory-array side.
interface weight_mem_loader_if #(
    parameter int numNeurons   = 32,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    s_valid;
    logic [31:0]             s_data;
    logic                    s_ready;
    logic [numNeurons-1:0]   wen;
    logic [7:0]              layer_sel;
    logic [addressWidth:0]   waddr;
    logic [dataWidth-1:0]    win;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport slave (
        input  s_valid, s_data,
        output s_ready, wen, layer_sel, waddr, win, busy, done, err
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, wen, layer_sel, waddr, win, busy, done, err
    );
endinterface

// File: rtl/weight_mem_loader.sv
// Streams header + N weight words into per-neuron weight memories (1-cycle write latency).
// Optional trailer checksum word: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_mem_loader #(
    parameter int numLayers    = 4,
    parameter int numNeurons   = 32,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    weight_mem_loader_if.slave bus
);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SKIP, S_CHECK, S_DONE} state_t;
    localparam state_t S_END = S_CHECK;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SKIP, S_DONE} state_t;
    localparam state_t S_END = S_DONE;
`endif

    localparam logic [8:0] LP_LAYERS  = 9'(numLayers);
    localparam logic [8:0] LP_NEURONS = 9'(numNeurons);
    localparam logic [addressWidth:0] LP_ADDR_ONE = {{addressWidth{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_ready_en;
    logic [7:0]              r_layer;
    logic [7:0]              r_neuron;
    logic [15:0]             r_rem;
    logic [addressWidth:0]   r_addr;
    logic [numNeurons-1:0]   r_wen;
    logic [addressWidth:0]   r_waddr;
    logic [dataWidth-1:0]    r_win;
    logic                    r_err;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [dataWidth-1:0]    r_sum;
`endif

    logic                    w_ready;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_accept;
    logic                    w_hdr_bad;
    logic                    w_hdr_nz;
    logic                    w_last;
    logic                    w_ovf;
    logic [numNeurons-1:0]   w_onehot;

    assign w_accept  = bus.s_valid && w_ready;
    assign w_hdr_bad = ({1'b0, bus.s_data[31:24]} >= LP_LAYERS) ||
                       ({1'b0, bus.s_data[23:16]} >= LP_NEURONS);
    assign w_hdr_nz  = (bus.s_data[15:0] != 16'd0);
    assign w_last    = (r_rem == 16'd1);
    // Address counter saturates at 2**addressWidth; that top bit marks overflow words.
    assign w_ovf     = r_addr[addressWidth];
    assign w_onehot  = {{(numNeurons-1){1'b0}}, 1'b1} << r_neuron;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = r_ready_en;
                if (w_accept) begin
                    if (!w_hdr_nz) begin
                        w_next = S_END;
                    end else if (w_hdr_bad) begin
                        w_next = S_SKIP;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD, S_SKIP: begin
                w_ready = r_ready_en;
                w_busy  = 1'b1;
                if (w_accept && w_last) begin
                    w_next = S_END;
                end
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready = r_ready_en;
                w_busy  = 1'b1;
                if (w_accept) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_layer    <= '0;
            r_neuron   <= '0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_wen      <= '0;
            r_waddr    <= '0;
            r_win      <= '0;
            r_err      <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_ready_en <= 1'b1;
            r_wen      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_layer  <= bus.s_data[31:24];
                        r_neuron <= bus.s_data[23:16];
                        r_rem    <= bus.s_data[15:0];
                        r_addr   <= '0;
                        r_err    <= w_hdr_bad;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        r_sum    <= '0;
`endif
                    end
                end
                S_LOAD, S_SKIP: begin
                    if (w_accept) begin
                        r_rem <= r_rem - 16'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + bus.s_data[dataWidth-1:0];
`endif
                        if (w_ovf) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr <= r_addr + LP_ADDR_ONE;
                            if (r_state == S_LOAD) begin
                                r_wen   <= w_onehot;
                                r_waddr <= r_addr;
                                r_win   <= bus.s_data[dataWidth-1:0];
                            end
                        end
                    end
                end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept && (bus.s_data[dataWidth-1:0] != r_sum)) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.wen       = r_wen;
    assign bus.layer_sel = r_layer;
    assign bus.waddr     = r_waddr;
    assign bus.win       = r_win;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: drivers queue expected writes/done events,
// a negedge monitor pops and compares them (including the cycle they must appear in).
module tb_weight_mem_loader;
    localparam int NL = 4;
    localparam int NN = 32;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_mem_loader_if #(.numNeurons(NN), .addressWidth(AW), .dataWidth(DW)) bus();

    weight_mem_loader #(
        .numLayers(NL), .numNeurons(NN), .addressWidth(AW), .dataWidth(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [NN-1:0] wen;
        logic [AW:0]   addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [7:0] layer;
        logic       err;
        int         cyc;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clk) begin : monitor
        wr_t w;
        dn_t d;
        if (rst_n) begin
            if (bus.wen !== '0) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 64'(bus.wen), 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("wr_wen",   64'(bus.wen),   64'(w.wen));
                    check("wr_addr",  64'(bus.waddr), 64'(w.addr));
                    check("wr_data",  64'(bus.win),   64'(w.data));
                    check("wr_cycle", 64'(cyc),       64'(w.cyc));
                end
            end
            if (bus.done !== 1'b0) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    d = dq.pop_front();
                    check("done_err",    64'(bus.err),       64'(d.err));
                    check("done_layer",  64'(bus.layer_sel), 64'(d.layer));
                    check("done_cycle",  64'(cyc),           64'(d.cyc));
                    check("done_ready",  64'(bus.s_ready),   64'd0);
                    check("done_busy",   64'(bus.busy),      64'd1);
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input int gap, output int hcyc);
        int t;
        bus.s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        t = 0;
        while (bus.s_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("ready_timeout", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        hcyc = cyc;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hDEAD_BEEF;
    endtask

    // Words are {16'hC0DE, base + i*step}; the upper half must never reach win.
    task automatic xfer(input logic [31:0] hdr, input int n, input logic [15:0] base,
                        input logic [15:0] step, input int gap, input logic exp_err,
                        input logic [15:0] tr_delta);
        int          h;
        logic [15:0] d;
        logic [15:0] sum;
        logic [NN-1:0] one;
        logic        ok;
        ok  = (hdr[31:24] < NL) && (hdr[23:16] < NN);
        one = 1;
        sum = '0;
        send(hdr, gap, h);
        for (int i = 0; i < n; i++) begin
            d = 16'(base + 16'(i) * step);
            send({16'hC0DE, d}, gap, h);
            sum = sum + d;
            if (ok && i < (1 << AW)) wq.push_back('{one << hdr[23:16], (AW+1)'(i), d, h});
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        send({16'h0000, 16'(sum + tr_delta)}, gap, h);
`endif
        dq.push_back('{hdr[31:24], exp_err, h});
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stim
        int h;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen",   64'(bus.wen),       64'd0);
        check("rst_waddr", 64'(bus.waddr),     64'd0);
        check("rst_win",   64'(bus.win),       64'd0);
        check("rst_layer", 64'(bus.layer_sel), 64'd0);
        check("rst_busy",  64'(bus.busy),      64'd0);
        check("rst_done",  64'(bus.done),      64'd0);
        check("rst_err",   64'(bus.err),       64'd0);
        check("rst_ready", 64'(bus.s_ready),   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(bus.s_ready), 64'd1);

        // layer 1, neuron 3, N=3: back-to-back, then with 2-cycle gaps
        xfer(32'h0103_0003, 3, 16'h1111, 16'h1111, 0, 1'b0, 16'd0);
        xfer(32'h0103_0003, 3, 16'h1111, 16'h1111, 2, 1'b0, 16'd0);

        // neuron out of range: words consumed, no writes, sticky err
        xfer(32'h0120_0002, 2, 16'h0042, 16'h0001, 0, 1'b1, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 64'(bus.err),  64'd1);
        check("idle_busy",  64'(bus.busy), 64'd0);

        // layer out of range
        xfer(32'h0400_0001, 1, 16'h7777, 16'h0000, 1, 1'b1, 16'd0);

        // N=0: DONE right after the last accepted word, s_ready low for one cycle
        xfer(32'h0205_0000, 0, 16'h0000, 16'h0000, 0, 1'b0, 16'd0);
        check("n0_ready_low", 64'(bus.s_ready), 64'd0);
        @(posedge clk);
        #1;
        check("n0_ready_back", 64'(bus.s_ready), 64'd1);

        // depth overflow: 1025 words, last one dropped
        xfer(32'h0007_0401, 1025, 16'h0100, 16'h0003, 0, 1'b1, 16'd0);

        // reset after 2 of 5 words
        send(32'h0302_0005, 0, h);
        for (int i = 0; i < 2; i++) begin
            send({16'h0000, 16'(16'h5000 + i)}, 0, h);
            wq.push_back('{32'h0000_0004, (AW+1)'(i), 16'(16'h5000 + i), h});
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_wen",   64'(bus.wen),     64'd0);
        check("midrst_busy",  64'(bus.busy),    64'd0);
        check("midrst_ready", 64'(bus.s_ready), 64'd0);
        check("midrst_waddr", 64'(bus.waddr),   64'd0);
        check("midrst_err",   64'(bus.err),     64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer(32'h0302_0002, 2, 16'hAAAA, 16'h1111, 0, 1'b0, 16'd0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        // words 1,2: trailer 3 is good, trailer 4 is bad
        xfer(32'h0001_0002, 2, 16'h0001, 16'h0001, 0, 1'b0, 16'd0);
        xfer(32'h0001_0002, 2, 16'h0001, 16'h0001, 0, 1'b1, 16'd1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("wq_empty", 64'(wq.size()), 64'd0);
        check("dq_empty", 64'(dq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
